// File: rtl/lvt_pkg.sv
// ============================================================================
// Module  : lvt_pkg
// Purpose : Shared definitions for the live-value-table block. Provides the
//           ceil-log2 helper, the entry-width derivation and the FSM state enum.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lvt_pkg;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of one table entry (the bank number). It is never narrower than one bit.
    function automatic int bank_w(input int num_wr);
        return (num_wr < 2) ? 1 : clog2(num_wr);
    endfunction

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } lvt_state_e;

endpackage

`default_nettype wire

// File: rtl/lvt_write_arbiter.sv
// ============================================================================
// Module  : lvt_write_arbiter
// Purpose : Resolves same-address writes among the write ports. The
//           highest-index enabled port wins. Lower-index ports that target the
//           same address are masked. A conflict flag is raised whenever two or
//           more enabled ports share an address.
// Ports   : i_we         - per-port write enable
//           i_write_addr - packed write addresses, port i at [i*ADDR_W +: ADDR_W]
//           o_eff_we     - per-port enable after priority masking
//           o_conflict   - combinational same-address multi-write flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lvt_write_arbiter
    import lvt_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        i_we,
    input  logic [NUM_WR*ADDR_W-1:0] i_write_addr,
    output logic [NUM_WR-1:0]        o_eff_we,
    output logic                     o_conflict
);

    // Each pair is checked once. When a pair collides, the lower index is the loser.
    always_comb begin
        o_eff_we   = i_we;
        o_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (i_we[i] && i_we[j] &&
                    (i_write_addr[i*ADDR_W +: ADDR_W] == i_write_addr[j*ADDR_W +: ADDR_W])) begin
                    o_eff_we[i] = 1'b0;
                    o_conflict  = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lvt_multiport.sv
// ============================================================================
// Module  : lvt_multiport
// Purpose : Live-value table for a multi-ported banked memory. Each entry
//           records which write port (bank) last wrote that address. After
//           reset, a clear sweep sets every entry to bank 0. The block then
//           serves NUM_WR writes and NUM_RD registered reads per cycle.
// Ports   : clock      - sole clock, rising edge
//           reset      - synchronous, active-high
//           we         - per-port write enable
//           write_addr - packed write addresses
//           read_addr  - packed read addresses
//           read_bank  - registered live bank per read port
//           busy       - high during the clear sweep
//           conflict   - registered pulse after a same-address multi-write
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lvt_multiport
    import lvt_pkg::*;
#(
    parameter int  ADDR_W = 5,
    parameter int  NUM_WR = 2,
    parameter int  NUM_RD = 4,
    parameter int  BYPASS = 0,
    localparam int BANK_W = bank_w(NUM_WR)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] write_addr,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*BANK_W-1:0] read_bank,
    output logic                     busy,
    output logic                     conflict
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

    lvt_state_e                state_q, state_d;
    logic [ADDR_W-1:0]         clr_cnt_q, clr_cnt_d;
    logic [BANK_W-1:0]         mem_q [DEPTH];
    logic [BANK_W-1:0]         mem_d [DEPTH];
    logic [NUM_RD*BANK_W-1:0]  read_bank_q, read_bank_d;
    logic                      conflict_q, conflict_d;

    logic [NUM_WR-1:0]         eff_we;
    logic                      arb_conflict;
    logic                      run;

    assign run = (state_q == ST_RUN);

    lvt_write_arbiter #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_arbiter (
        .i_we         (we),
        .i_write_addr (write_addr),
        .o_eff_we     (eff_we),
        .o_conflict   (arb_conflict)
    );

    // The sweep counter wraps to 0 on the same edge that leaves CLEAR. RUN is
    // sticky until reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == LAST_ENTRY) begin
                state_d = ST_RUN;
            end
        end
    end

    // Storage update. Reset blocks every write. This drops pending RUN writes,
    // and the sweep restarts anyway. The arbiter guarantees at most one
    // effective writer per address, so loop order does not matter.
    always_comb begin
        mem_d = mem_q;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_d[clr_cnt_q] = '0;
            end else begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (eff_we[i]) begin
                        mem_d[write_addr[i*ADDR_W +: ADDR_W]] = BANK_W'(i);
                    end
                end
            end
        end
    end

    // Read path. The pre-write entry is returned unless forwarding is enabled.
    // With forwarding, only the winning writer for an address can match, since
    // losers are already masked in eff_we.
    always_comb begin
        read_bank_d = '0;
        conflict_d  = run & arb_conflict;
        if (run) begin
            for (int j = 0; j < NUM_RD; j++) begin
                read_bank_d[j*BANK_W +: BANK_W] = mem_q[read_addr[j*ADDR_W +: ADDR_W]];
                if (BYPASS != 0) begin
                    for (int i = 0; i < NUM_WR; i++) begin
                        if (eff_we[i] &&
                            (write_addr[i*ADDR_W +: ADDR_W] == read_addr[j*ADDR_W +: ADDR_W])) begin
                            read_bank_d[j*BANK_W +: BANK_W] = BANK_W'(i);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            read_bank_q <= '0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            read_bank_q <= read_bank_d;
            conflict_q  <= conflict_d;
        end
    end

    // The table has no reset. Its contents are established by the sweep.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign read_bank = read_bank_q;
    assign busy      = (state_q == ST_CLEAR);
    assign conflict  = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_lvt_multiport.sv
// ============================================================================
// Module  : tb_lvt_multiport
// Purpose : Testbench for lvt_multiport. Instance 0 uses the default
//           parameters with forwarding off. Instance 1 uses NUM_WR=4,
//           NUM_RD=8 with forwarding on.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lvt_multiport;

    localparam int DEPTH = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance 0: NUM_WR=2, NUM_RD=4, BYPASS=0
    logic            rst0;
    logic [1:0]      we0;
    logic [1:0][4:0] wa0;
    logic [3:0][4:0] ra0;
    logic [3:0]      rb0;
    logic            busy0, conf0;

    // Instance 1: NUM_WR=4, NUM_RD=8, BYPASS=1
    logic            rst1;
    logic [3:0]      we1;
    logic [3:0][4:0] wa1;
    logic [7:0][4:0] ra1;
    logic [7:0][1:0] rb1;
    logic            busy1, conf1;

    lvt_multiport #(.ADDR_W(5), .NUM_WR(2), .NUM_RD(4), .BYPASS(0)) u_dut0 (
        .clock      (clock),
        .reset      (rst0),
        .we         (we0),
        .write_addr (wa0),
        .read_addr  (ra0),
        .read_bank  (rb0),
        .busy       (busy0),
        .conflict   (conf0)
    );

    lvt_multiport #(.ADDR_W(5), .NUM_WR(4), .NUM_RD(8), .BYPASS(1)) u_dut1 (
        .clock      (clock),
        .reset      (rst1),
        .we         (we1),
        .write_addr (wa1),
        .read_addr  (ra1),
        .read_bank  (rb1),
        .busy       (busy1),
        .conflict   (conf1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- table-driven vectors for instance 0 -------------------
    typedef struct {
        logic [1:0]      we;
        logic [1:0][4:0] wa;
        logic [3:0][4:0] ra;
        logic [3:0]      rb;
        logic            cf;
    } vec_t;

    function automatic vec_t mkv(input logic [1:0] we, input int w0, input int w1,
                                 input int r0, input int r1, input int r2, input int r3,
                                 input logic b0, input logic b1, input logic b2, input logic b3,
                                 input logic cf);
        vec_t v;
        v.we    = we;
        v.wa[0] = 5'(w0);
        v.wa[1] = 5'(w1);
        v.ra[0] = 5'(r0);
        v.ra[1] = 5'(r1);
        v.ra[2] = 5'(r2);
        v.ra[3] = 5'(r3);
        v.rb    = {b3, b2, b1, b0};
        v.cf    = cf;
        return v;
    endfunction

    vec_t tbl[11];

    // ---------------- reference model for instance 1 ------------------------
    int mem1[DEPTH];
    int clr_left = DEPTH;

    task automatic step1(input logic rst, input logic [3:0] we, input logic [3:0][4:0] wa,
                         input logic [7:0][4:0] ra);
        int exp_rb[8];
        int exp_cf;
        int exp_busy;
        exp_cf = 0;
        for (int j = 0; j < 8; j++) exp_rb[j] = 0;
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) mem1[a] = 0;
            clr_left = DEPTH;
            exp_busy = 1;
        end else if (clr_left > 0) begin
            clr_left--;
            exp_busy = (clr_left > 0) ? 1 : 0;
        end else begin
            exp_busy = 0;
            for (int j = 0; j < 8; j++) begin
                exp_rb[j] = mem1[ra[j]];
                for (int i = 0; i < 4; i++)
                    if (we[i] && wa[i] == ra[j]) exp_rb[j] = i;
            end
            for (int i = 0; i < 4; i++)
                for (int k = i + 1; k < 4; k++)
                    if (we[i] && we[k] && wa[i] == wa[k]) exp_cf = 1;
            for (int i = 0; i < 4; i++)
                if (we[i]) mem1[wa[i]] = i;
        end
        rst1 = rst;
        we1  = we;
        wa1  = wa;
        ra1  = ra;
        tick();
        for (int j = 0; j < 8; j++) chk($sformatf("dut1 read_bank[%0d]", j), 32'(rb1[j]), 32'(exp_rb[j]));
        chk("dut1 conflict", 32'(conf1), 32'(exp_cf));
        chk("dut1 busy", 32'(busy1), 32'(exp_busy));
    endtask

    initial begin
        int n;
        logic [3:0]      rwe;
        logic [3:0][4:0] rwa;
        logic [7:0][4:0] rra;

        rst0 = 1'b1; we0 = '0; wa0 = '0; ra0 = '0;
        rst1 = 1'b1; we1 = '0; wa1 = '0; ra1 = '0;

        // ---------------- instance 0: reset and clear sweep ------------------
        tick();
        chk("dut0 reset busy", 32'(busy0), 32'd1);
        chk("dut0 reset conflict", 32'(conf0), 32'd0);
        chk("dut0 reset read_bank", 32'(rb0), 32'd0);

        // Colliding writes during the sweep must be ignored.
        rst0 = 1'b0;
        we0  = 2'b11;
        wa0[0] = 5'd9; wa0[1] = 5'd9;
        ra0[0] = 5'd9;
        n = 0;
        while (busy0 && n < 100) begin
            tick();
            n++;
            chk("dut0 clear conflict", 32'(conf0), 32'd0);
            chk("dut0 clear read_bank", 32'(rb0), 32'd0);
        end
        chk("dut0 sweep length", 32'(n), 32'd32);
        we0 = '0;

        for (int base = 0; base < DEPTH; base += 4) begin
            for (int j = 0; j < 4; j++) ra0[j] = 5'(base + j);
            tick();
            chk($sformatf("dut0 cleared entries %0d..%0d", base, base + 3), 32'(rb0), 32'd0);
        end

        // ---------------- instance 0: vector table ---------------------------
        tbl[0]  = mkv(2'b11, 3, 7,   3, 7, 0, 1,    0, 0, 0, 0, 0);
        tbl[1]  = mkv(2'b00, 0, 0,   3, 7, 9, 4,    0, 1, 0, 0, 0);
        tbl[2]  = mkv(2'b11, 9, 9,   9, 3, 7, 2,    0, 0, 1, 0, 1);
        tbl[3]  = mkv(2'b00, 0, 0,   9, 7, 3, 9,    1, 1, 0, 1, 0);
        tbl[4]  = mkv(2'b10, 0, 4,   4, 9, 4, 0,    0, 1, 0, 0, 0);
        tbl[5]  = mkv(2'b00, 0, 0,   4, 4, 0, 7,    1, 1, 0, 1, 0);
        tbl[6]  = mkv(2'b01, 7, 7,   7, 4, 9, 3,    1, 1, 1, 0, 0);
        tbl[7]  = mkv(2'b00, 0, 0,   7, 4, 9, 3,    0, 1, 1, 0, 0);
        tbl[8]  = mkv(2'b11, 4, 20,  20, 4, 31, 9,  0, 1, 0, 1, 0);
        tbl[9]  = mkv(2'b11, 20, 20, 20, 4, 9, 7,   1, 0, 1, 0, 1);
        tbl[10] = mkv(2'b00, 0, 0,   20, 4, 31, 0,  1, 0, 0, 0, 0);

        for (int k = 0; k < 11; k++) begin
            we0 = tbl[k].we;
            wa0 = tbl[k].wa;
            ra0 = tbl[k].ra;
            tick();
            for (int j = 0; j < 4; j++)
                chk($sformatf("dut0 vec%0d read_bank[%0d]", k, j), 32'(rb0[j]), 32'(tbl[k].rb[j]));
            chk($sformatf("dut0 vec%0d conflict", k), 32'(conf0), 32'(tbl[k].cf));
        end
        we0 = '0;

        // ---------------- instance 0: reset mid-sweep ------------------------
        we0 = 2'b10; wa0[1] = 5'd5;
        tick();
        we0 = '0; ra0[0] = 5'd5;
        tick();
        chk("dut0 entry5 before reset", 32'(rb0[0]), 32'd1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        repeat (10) tick();
        chk("dut0 busy mid-sweep", 32'(busy0), 32'd1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        n = 0;
        while (busy0 && n < 100) begin
            tick();
            n++;
        end
        chk("dut0 restarted sweep length", 32'(n), 32'd32);
        tick();
        chk("dut0 entry5 after restart", 32'(rb0[0]), 32'd0);

        // ---------------- instance 1: reset, clear, forwarding ---------------
        step1(1'b1, '0, '0, '0);
        for (int c = 0; c < DEPTH; c++) step1(1'b0, '0, '0, '0);

        rwa = '0; rra = '0;
        rwa[1] = 5'd4; rra[0] = 5'd4;
        step1(1'b0, 4'b0010, rwa, rra);
        chk("dut1 forward port1", 32'(rb1[0]), 32'd1);

        rwa = '0; rra = '0;
        rwa[1] = 5'd6; rwa[3] = 5'd6; rra[0] = 5'd6;
        step1(1'b0, 4'b1010, rwa, rra);
        chk("dut1 forward winner port3", 32'(rb1[0]), 32'd3);
        chk("dut1 forward conflict", 32'(conf1), 32'd1);

        // ---------------- instance 1: randomized against the model -----------
        for (int c = 0; c < 10000; c++) begin
            rwe = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++)
                rwa[i] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            for (int j = 0; j < 8; j++)
                rra[j] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            step1(($urandom_range(0, 999) == 0), rwe, rwa, rra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lvt_multiport.md
LVT_MULTIPORT -- requirements
Module: lvt_multiport

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, table address width; DEPTH = 2**ADDR_W entries.
REQ-002 SHALL have parameter NUM_WR, default 2, write-port (bank) count, range 2..8.
REQ-003 SHALL have parameter NUM_RD, default 4, read-port count, range 1..8.
REQ-004 SHALL have parameter BYPASS, default 0, enabling same-cycle write-to-read forwarding when 1.
REQ-005 SHALL derive BANK_W = clog2(NUM_WR), the width of one table entry.
REQ-006 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port we, input, NUM_WR, per-port write enable.
REQ-009 SHALL have port write_addr, input, NUM_WR*ADDR_W, packed write addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port read_addr, input, NUM_RD*ADDR_W, packed read addresses, same packing.
REQ-011 SHALL have port read_bank, output, NUM_RD*BANK_W, registered live bank per read port.
REQ-012 SHALL have port busy, output, 1, high while the table clear sweep runs.
REQ-013 SHALL have port conflict, output, 1, registered one-cycle pulse flagging a same-address multi-write.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-015 CLEAR SHALL write bank 0 to entry clr_cnt each cycle, incrementing clr_cnt from 0 to DEPTH-1, then enter RUN on the following cycle.
REQ-016 busy SHALL be 1 in CLEAR and 0 in RUN; the sweep takes exactly DEPTH cycles after reset deasserts.
REQ-017 In CLEAR, we SHALL be ignored, conflict SHALL stay 0, and read_bank SHALL register 0 on every port.
REQ-018 In RUN, each enabled write port i SHALL set entry write_addr[i] to bank value i at the clock edge.
REQ-019 When two or more enabled ports share an address, the highest-index port SHALL win; the lower-index writes to that address are dropped.
REQ-020 conflict SHALL be 1 in the cycle after any RUN-state edge at which a same-address multi-write occurred, else 0.
REQ-021 Read latency SHALL be 1 cycle: read_bank[j] at edge N+1 reflects read_addr[j] sampled at edge N.
REQ-022 With BYPASS=0, a read that matches a same-cycle write address SHALL return the pre-write entry.
REQ-023 With BYPASS=1, such a read SHALL return the winning write's bank per REQ-019.
REQ-024 Writes to distinct addresses in one cycle SHALL all take effect; NUM_RD reads SHALL be independent and simultaneous.
REQ-025 clr_cnt SHALL wrap from DEPTH-1 only into the CLEAR-to-RUN transition and never re-enter CLEAR except via reset.

Reset
REQ-026 On any edge where reset=1, the block SHALL enter CLEAR with clr_cnt=0, busy=1, conflict=0, and all read_bank=0.
REQ-027 reset asserted mid-sweep SHALL restart the sweep at entry 0; reset asserted in RUN SHALL abort all pending writes.
REQ-028 Table contents SHALL be defined only by the clear sweep; no reset fan-out to the storage array.

Structure
REQ-029 A shared package lvt_pkg SHALL hold the clog2 function, the FSM state enum, and the BANK_W derivation.
REQ-030 Per-address priority and conflict detection SHALL live in sub-module lvt_write_arbiter, which outputs per-port effective write enables and a conflict flag.
REQ-031 Storage SHALL be a DEPTH x BANK_W register array with NUM_WR write ports and NUM_RD read ports.

Verification
REQ-032 Reset for 1 cycle, ADDR_W=5 -> busy=1 for exactly 32 cycles, then 0; all reads return 0.
REQ-033 RUN: we=2'b11, write_addr0=3, write_addr1=7; next cycle read addr 3 and 7 -> read_bank 0 and 1, conflict=0.
REQ-034 RUN: we=2'b11, both addresses 9 -> entry 9 reads 1; conflict=1 for exactly one cycle.
REQ-035 BYPASS=0 vs 1: port1 writes address 4 while read_addr0=4 in the same cycle -> read_bank0=0 (BYPASS=0) or 1 (BYPASS=1).
REQ-036 Write entry 5 to bank 1, assert reset at sweep cycle 10, release -> busy lasts a full 32 cycles from release; entry 5 then reads 0.
REQ-037 NUM_WR=4, NUM_RD=8: random writes versus a reference model over 10k cycles -> zero mismatches.
